// File: rtl/kamikaze_operand_fetch.sv
// Operand fetch stage: resolves source operands with writeback bypass, tracks
// in-flight destination writes in a scoreboard and hands operands to execute.
module kamikaze_operand_fetch (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        id_valid_i,
  output logic        id_ready_o,
  input  logic [4:0]  id_rs1_i,
  input  logic [4:0]  id_rs2_i,
  input  logic [4:0]  id_rd_i,
  input  logic        id_rd_we_i,
  output logic [4:0]  rf_raddr1_o,
  output logic [4:0]  rf_raddr2_o,
  input  logic [31:0] rf_rdata1_i,
  input  logic [31:0] rf_rdata2_i,
  input  logic        wb_valid_i,
  input  logic [4:0]  wb_addr_i,
  input  logic [31:0] wb_data_i,
  input  logic        flush_i,
  output logic        ex_valid_o,
  input  logic        ex_ready_i,
  output logic [31:0] ex_rs1_data_o,
  output logic [31:0] ex_rs2_data_o,
  output logic [4:0]  ex_rd_o,
  output logic        ex_rd_we_o,
  output logic [15:0] stall_cnt_o
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned AW   = 5;
  localparam int unsigned NREG = 32;
  localparam int unsigned CW   = 16;

  logic [NREG-1:0] r_sb;
  logic [NREG-1:0] w_sb_nxt;
  logic            r_ex_valid;
  logic [XLEN-1:0] r_ex_rs1_data;
  logic [XLEN-1:0] r_ex_rs2_data;
  logic [AW-1:0]   r_ex_rd;
  logic            r_ex_rd_we;
  logic [CW-1:0]   r_stall_cnt;

  logic            w_wb_hit1;
  logic            w_wb_hit2;
  logic            w_wb_hit_rd;
  logic            w_raw1;
  logic            w_raw2;
  logic            w_waw;
  logic            w_hazard;
  logic            w_ex_free;
  logic            w_ready;
  logic            w_accept;
  logic            w_set;
  logic            w_flush_clr;
  logic [XLEN-1:0] w_rs1_data;
  logic [XLEN-1:0] w_rs2_data;

  assign rf_raddr1_o = id_rs1_i;
  assign rf_raddr2_o = id_rs2_i;

  // Writeback matches on each operand and on the destination
  assign w_wb_hit1   = wb_valid_i && (wb_addr_i == id_rs1_i);
  assign w_wb_hit2   = wb_valid_i && (wb_addr_i == id_rs2_i);
  assign w_wb_hit_rd = wb_valid_i && (wb_addr_i == id_rd_i);

  // x0 reads as zero; a same-cycle writeback wins over the register file
  always_comb begin
    w_rs1_data = rf_rdata1_i;
    w_rs2_data = rf_rdata2_i;
    if (w_wb_hit1) w_rs1_data = wb_data_i;
    if (w_wb_hit2) w_rs2_data = wb_data_i;
    if (id_rs1_i == '0) w_rs1_data = '0;
    if (id_rs2_i == '0) w_rs2_data = '0;
  end

  assign w_raw1   = (id_rs1_i != '0) && r_sb[id_rs1_i] && !w_wb_hit1;
  assign w_raw2   = (id_rs2_i != '0) && r_sb[id_rs2_i] && !w_wb_hit2;
  assign w_waw    = id_rd_we_i && (id_rd_i != '0) && r_sb[id_rd_i] && !w_wb_hit_rd;
  assign w_hazard = id_valid_i && (w_raw1 || w_raw2 || w_waw);

  assign w_ex_free  = !r_ex_valid || ex_ready_i;
  assign w_ready    = !w_hazard && !flush_i && w_ex_free;
  assign w_accept   = id_valid_i && w_ready;
  assign id_ready_o = w_ready;

  assign w_set       = w_accept && id_rd_we_i && (id_rd_i != '0);
  assign w_flush_clr = flush_i && r_ex_valid && r_ex_rd_we &&
                       !(w_set && (id_rd_i == r_ex_rd));

  // Scoreboard update: clears first so a same-bit set takes priority
  always_comb begin
    w_sb_nxt = r_sb;
    if (wb_valid_i)  w_sb_nxt[wb_addr_i] = 1'b0;
    if (w_flush_clr) w_sb_nxt[r_ex_rd]   = 1'b0;
    if (w_set)       w_sb_nxt[id_rd_i]   = 1'b1;
    w_sb_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_sb <= '0;
    end else begin
      r_sb <= w_sb_nxt;
    end
  end

  // Execute-side pipeline register; payload holds while stalled or flushed
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_ex_valid    <= 1'b0;
      r_ex_rs1_data <= '0;
      r_ex_rs2_data <= '0;
      r_ex_rd       <= '0;
      r_ex_rd_we    <= 1'b0;
    end else if (flush_i) begin
      r_ex_valid <= 1'b0;
    end else if (w_accept) begin
      r_ex_valid    <= 1'b1;
      r_ex_rs1_data <= w_rs1_data;
      r_ex_rs2_data <= w_rs2_data;
      r_ex_rd       <= id_rd_i;
      r_ex_rd_we    <= id_rd_we_i;
    end else if (r_ex_valid && ex_ready_i) begin
      r_ex_valid <= 1'b0;
    end
  end

  // Saturating hazard stall counter
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_stall_cnt <= '0;
    end else if (w_hazard && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + CW'(1);
    end
  end

  assign ex_valid_o    = r_ex_valid;
  assign ex_rs1_data_o = r_ex_rs1_data;
  assign ex_rs2_data_o = r_ex_rs2_data;
  assign ex_rd_o       = r_ex_rd;
  assign ex_rd_we_o    = r_ex_rd_we;
  assign stall_cnt_o   = r_stall_cnt;

endmodule

// File: tb/tb_kamikaze_operand_fetch.sv
// Self-checking bench for kamikaze_operand_fetch: expected execute payloads are
// queued at issue time and compared whenever execute takes a transfer.
module tb_kamikaze_operand_fetch;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic        we;
  } exp_t;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        id_valid_i;
  logic        id_ready_o;
  logic [4:0]  id_rs1_i, id_rs2_i, id_rd_i;
  logic        id_rd_we_i;
  logic [4:0]  rf_raddr1_o, rf_raddr2_o;
  logic [31:0] rf_rdata1_i, rf_rdata2_i;
  logic        wb_valid_i;
  logic [4:0]  wb_addr_i;
  logic [31:0] wb_data_i;
  logic        flush_i;
  logic        ex_valid_o;
  logic        ex_ready_i;
  logic [31:0] ex_rs1_data_o, ex_rs2_data_o;
  logic [4:0]  ex_rd_o;
  logic        ex_rd_we_o;
  logic [15:0] stall_cnt_o;

  int   checks = 0;
  int   errors = 0;
  int   exp_stall = 0;
  exp_t q[$];
  exp_t held;

  kamikaze_operand_fetch dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .id_valid_i(id_valid_i), .id_ready_o(id_ready_o),
    .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i), .id_rd_i(id_rd_i), .id_rd_we_i(id_rd_we_i),
    .rf_raddr1_o(rf_raddr1_o), .rf_raddr2_o(rf_raddr2_o),
    .rf_rdata1_i(rf_rdata1_i), .rf_rdata2_i(rf_rdata2_i),
    .wb_valid_i(wb_valid_i), .wb_addr_i(wb_addr_i), .wb_data_i(wb_data_i),
    .flush_i(flush_i),
    .ex_valid_o(ex_valid_o), .ex_ready_i(ex_ready_i),
    .ex_rs1_data_o(ex_rs1_data_o), .ex_rs2_data_o(ex_rs2_data_o),
    .ex_rd_o(ex_rd_o), .ex_rd_we_o(ex_rd_we_o),
    .stall_cnt_o(stall_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] exp_op(input logic [4:0] idx, input logic [31:0] rf);
    if (idx == 5'd0) return 32'd0;
    if (wb_valid_i && wb_addr_i == idx) return wb_data_i;
    return rf;
  endfunction

  task automatic push_exp();
    exp_t e;
    e.a  = exp_op(id_rs1_i, rf_rdata1_i);
    e.b  = exp_op(id_rs2_i, rf_rdata2_i);
    e.rd = id_rd_i;
    e.we = id_rd_we_i;
    q.push_back(e);
  endtask

  task automatic issue(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                       input logic we, input logic [31:0] d1, input logic [32-1:0] d2);
    id_valid_i  = 1'b1;
    id_rs1_i    = rs1;
    id_rs2_i    = rs2;
    id_rd_i     = rd;
    id_rd_we_i  = we;
    rf_rdata1_i = d1;
    rf_rdata2_i = d2;
    #1;
  endtask

  // Advance one cycle; at the falling edge compare any execute transfer
  task automatic tick();
    exp_t e;
    @(negedge clk_i);
    if (rst_n_i && ex_valid_o && ex_ready_i) begin
      if (q.size() == 0) begin
        errors++;
        $display("FAIL xfer_unexpected: got rs1=%h rs2=%h rd=%0d we=%b, required no transfer",
                 ex_rs1_data_o, ex_rs2_data_o, ex_rd_o, ex_rd_we_o);
      end else begin
        e = q.pop_front();
        if ({ex_rs1_data_o, ex_rs2_data_o, ex_rd_o, ex_rd_we_o} !== e) begin
          errors++;
          $display("FAIL xfer_payload: got rs1=%h rs2=%h rd=%0d we=%b, required rs1=%h rs2=%h rd=%0d we=%b",
                   ex_rs1_data_o, ex_rs2_data_o, ex_rd_o, ex_rd_we_o, e.a, e.b, e.rd, e.we);
        end
      end
      checks++;
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    rst_n_i = 1'b0; flush_i = 1'b0; ex_ready_i = 1'b1; wb_valid_i = 1'b0;
    wb_addr_i = '0; wb_data_i = '0;
    issue(5'd1, 5'd2, 5'd3, 1'b1, 32'h1234_5678, 32'h9abc_def0);
    tick(); tick();
    if ({ex_valid_o, ex_rs1_data_o, ex_rs2_data_o, ex_rd_o, ex_rd_we_o} !== '0) begin
      errors++;
      $display("FAIL reset_ex: got v=%b rs1=%h rs2=%h rd=%0d we=%b, required all 0",
               ex_valid_o, ex_rs1_data_o, ex_rs2_data_o, ex_rd_o, ex_rd_we_o);
    end
    checks++;
    if (stall_cnt_o !== 16'd0) begin
      errors++; $display("FAIL reset_stall: got %h, required 0000", stall_cnt_o);
    end
    checks++;
    id_valid_i = 1'b0;
    rst_n_i = 1'b1;
    #1;
    if (id_ready_o !== 1'b1) begin
      errors++; $display("FAIL reset_ready: got %b, required 1", id_ready_o);
    end
    checks++;
    flush_i = 1'b1; #1;
    if (id_ready_o !== 1'b0) begin
      errors++; $display("FAIL reset_ready_flush: got %b, required 0", id_ready_o);
    end
    checks++;
    flush_i = 1'b0;
    // The instruction shown during reset must not have left x3 busy
    issue(5'd3, 5'd0, 5'd0, 1'b0, 32'h0000_0333, 32'h0);
    if (rf_raddr1_o !== 5'd3 || rf_raddr2_o !== 5'd0) begin
      errors++; $display("FAIL raddr: got %0d/%0d, required 3/0", rf_raddr1_o, rf_raddr2_o);
    end
    checks++;
    if (id_ready_o !== 1'b1) begin
      errors++; $display("FAIL reset_no_residue: got ready %b, required 1", id_ready_o);
    end
    checks++;
    push_exp(); tick();
    id_valid_i = 1'b0; tick();
  endtask

  task automatic test_bypass();
    wb_valid_i = 1'b1; wb_addr_i = 5'd5; wb_data_i = 32'hDEAD_BEEF;
    issue(5'd5, 5'd3, 5'd0, 1'b0, 32'h1111_1111, 32'h2222_2222);
    if (id_ready_o !== 1'b1) begin
      errors++; $display("FAIL bypass_ready: got %b, required 1", id_ready_o);
    end
    checks++;
    push_exp(); tick();
    wb_valid_i = 1'b0; id_valid_i = 1'b0;
    if (ex_valid_o !== 1'b1 || ex_rs1_data_o !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL bypass_rs1: got v=%b %h, required v=1 deadbeef", ex_valid_o, ex_rs1_data_o);
    end
    checks++;
    tick();
  endtask

  task automatic test_x0();
    issue(5'd0, 5'd0, 5'd0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    push_exp(); tick();
    if (ex_rs1_data_o !== 32'd0 || ex_rs2_data_o !== 32'd0) begin
      errors++; $display("FAIL x0_operands: got %h %h, required 0 0", ex_rs1_data_o, ex_rs2_data_o);
    end
    checks++;
    issue(5'd0, 5'd0, 5'd0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    if (id_ready_o !== 1'b1) begin
      errors++; $display("FAIL x0_no_waw: got ready %b, required 1", id_ready_o);
    end
    checks++;
    push_exp(); tick();
    id_valid_i = 1'b0; tick();
  endtask

  task automatic test_raw();
    issue(5'd1, 5'd2, 5'd7, 1'b1, 32'h0000_0101, 32'h0000_0202);
    push_exp(); tick();
    issue(5'd0, 5'd7, 5'd8, 1'b1, 32'h0, 32'h7777_7777);
    for (int k = 0; k < 3; k++) begin
      if (id_ready_o !== 1'b0) begin
        errors++; $display("FAIL raw_ready: got %b, required 0", id_ready_o);
      end
      checks++;
      tick();
      exp_stall++;
      if (stall_cnt_o !== 16'(exp_stall)) begin
        errors++; $display("FAIL raw_stall_cnt: got %0d, required %0d", stall_cnt_o, exp_stall);
      end
      checks++;
    end
    wb_valid_i = 1'b1; wb_addr_i = 5'd7; wb_data_i = 32'h42; #1;
    if (id_ready_o !== 1'b1) begin
      errors++; $display("FAIL raw_release: got ready %b, required 1", id_ready_o);
    end
    checks++;
    push_exp(); tick();
    wb_valid_i = 1'b0; id_valid_i = 1'b0;
    if (ex_rs2_data_o !== 32'h42 || stall_cnt_o !== 16'(exp_stall)) begin
      errors++; $display("FAIL raw_bypass: got rs2=%h cnt=%0d, required 42 cnt=%0d",
                         ex_rs2_data_o, stall_cnt_o, exp_stall);
    end
    checks++;
    wb_valid_i = 1'b1; wb_addr_i = 5'd8; wb_data_i = 32'h88;
    tick();
    wb_valid_i = 1'b0;
  endtask

  task automatic test_backpressure();
    ex_ready_i = 1'b0;
    issue(5'd1, 5'd2, 5'd11, 1'b0, 32'h0000_00A1, 32'h0000_00A2);
    push_exp(); held = q[q.size()-1];
    tick();
    issue(5'd3, 5'd4, 5'd12, 1'b0, 32'h0000_00B3, 32'h0000_00B4);
    for (int k = 0; k < 3; k++) begin
      if (id_ready_o !== 1'b0 || ex_valid_o !== 1'b1) begin
        errors++; $display("FAIL bp_ready: got ready=%b v=%b, required 0 1", id_ready_o, ex_valid_o);
      end
      checks++;
      if ({ex_rs1_data_o, ex_rs2_data_o, ex_rd_o, ex_rd_we_o} !== held) begin
        errors++; $display("FAIL bp_hold: got %h %h %0d, required %h %h %0d",
                           ex_rs1_data_o, ex_rs2_data_o, ex_rd_o, held.a, held.b, held.rd);
      end
      checks++;
      tick();
    end
    ex_ready_i = 1'b1; #1;
    if (id_ready_o !== 1'b1) begin
      errors++; $display("FAIL bp_resume: got ready %b, required 1", id_ready_o);
    end
    checks++;
    push_exp(); tick();
    id_valid_i = 1'b0; tick();
  endtask

  task automatic test_flush();
    ex_ready_i = 1'b0;
    issue(5'd2, 5'd4, 5'd9, 1'b1, 32'h0000_0F02, 32'h0000_0F04);
    push_exp(); tick();
    id_valid_i = 1'b0; flush_i = 1'b1; #1;
    if (id_ready_o !== 1'b0) begin
      errors++; $display("FAIL flush_ready: got %b, required 0", id_ready_o);
    end
    checks++;
    void'(q.pop_front());
    tick();
    flush_i = 1'b0;
    if (ex_valid_o !== 1'b0) begin
      errors++; $display("FAIL flush_valid: got %b, required 0", ex_valid_o);
    end
    checks++;
    ex_ready_i = 1'b1;
    issue(5'd9, 5'd0, 5'd0, 1'b0, 32'h0000_0909, 32'h0);
    if (id_ready_o !== 1'b1) begin
      errors++; $display("FAIL flush_sb_clear: got ready %b, required 1", id_ready_o);
    end
    checks++;
    push_exp(); tick();
    if (stall_cnt_o !== 16'(exp_stall)) begin
      errors++; $display("FAIL flush_no_stall: got %0d, required %0d", stall_cnt_o, exp_stall);
    end
    checks++;
    id_valid_i = 1'b0; tick();
  endtask

  task automatic test_back_to_back();
    ex_ready_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      issue(5'(i + 1), 5'(i + 2), 5'(10 + i), 1'b0, $urandom, $urandom);
      if (id_ready_o !== 1'b1) begin
        errors++; $display("FAIL b2b_ready[%0d]: got %b, required 1", i, id_ready_o);
      end
      checks++;
      push_exp(); tick();
    end
    id_valid_i = 1'b0; tick();
  endtask

  task automatic test_saturation();
    issue(5'd0, 5'd0, 5'd20, 1'b1, 32'h0, 32'h0);
    push_exp(); tick();
    issue(5'd20, 5'd1, 5'd0, 1'b0, 32'h5A5A_5A5A, 32'hA5A5_A5A5);
    if (id_ready_o !== 1'b0) begin
      errors++; $display("FAIL sat_hazard: got ready %b, required 0", id_ready_o);
    end
    checks++;
    repeat (70000) tick();
    if (stall_cnt_o !== 16'hFFFF) begin
      errors++; $display("FAIL sat_cnt: got %h, required ffff", stall_cnt_o);
    end
    checks++;
    if (ex_rd_o !== 5'd20 || ex_rd_we_o !== 1'b1) begin
      errors++; $display("FAIL sat_ex_hold: got rd=%0d we=%b, required 20 1", ex_rd_o, ex_rd_we_o);
    end
    checks++;
    #2 rst_n_i = 1'b0;
    #1;
    if ({ex_valid_o, ex_rs1_data_o, ex_rs2_data_o, ex_rd_o, ex_rd_we_o} !== '0 ||
        stall_cnt_o !== 16'd0) begin
      errors++;
      $display("FAIL async_reset: got v=%b rs1=%h rs2=%h rd=%0d we=%b cnt=%h, required all 0",
               ex_valid_o, ex_rs1_data_o, ex_rs2_data_o, ex_rd_o, ex_rd_we_o, stall_cnt_o);
    end
    checks++;
    q.delete();
    tick();
    rst_n_i = 1'b1; #1;
    if (id_ready_o !== 1'b1 || ex_valid_o !== 1'b0) begin
      errors++; $display("FAIL reset_clears_sb: got ready=%b v=%b, required 1 0", id_ready_o, ex_valid_o);
    end
    checks++;
    id_valid_i = 1'b0; tick();
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_x0();
    test_raw();
    test_backpressure();
    test_flush();
    test_back_to_back();
    test_saturation();
    if (q.size() != 0) begin
      errors++; $display("FAIL queue_drain: got %0d pending, required 0", q.size());
    end
    checks++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/kamikaze_operand_fetch.md
KAMIKAZE_OPERAND_FETCH -- requirements
Module: kamikaze_operand_fetch

Interface
REQ-001 SHALL have exactly one clock, clk_i, with all state updating on its rising edge.
REQ-002 SHALL have reset rst_n_i, asynchronous, active-low.
REQ-003 SHALL have these ports (name, direction, width, meaning):
- clk_i  in  1  clock
- rst_n_i  in  1  async active-low reset
- id_valid_i  in  1  decoded instruction present
- id_ready_o  out  1  stage accepts instruction this cycle
- id_rs1_i, id_rs2_i  in  5  source register indices
- id_rd_i  in  5  destination index
- id_rd_we_i  in  1  instruction writes rd
- rf_raddr1_o, rf_raddr2_o  out  5  register file read addresses
- rf_rdata1_i, rf_rdata2_i  in  32  register file read data (combinational)
- wb_valid_i  in  1  writeback this cycle
- wb_addr_i  in  5  writeback index
- wb_data_i  in  32  writeback data
- flush_i  in  1  discard held instruction
- ex_valid_o  out  1  operands valid to execute
- ex_ready_i  in  1  execute accepts
- ex_rs1_data_o, ex_rs2_data_o  out  32  resolved operands
- ex_rd_o  out  5  destination index
- ex_rd_we_o  out  1  destination write enable
- stall_cnt_o  out  16  hazard stall cycle count

Function
REQ-004 SHALL drive rf_raddr1_o=id_rs1_i and rf_raddr2_o=id_rs2_i combinationally.
REQ-005 SHALL resolve each operand as: index 0 -> 0; else wb_valid_i && wb_addr_i==index -> wb_data_i; else register file data.
REQ-006 SHALL keep a 32-bit scoreboard, with bit n meaning a write to xn is in flight; bit 0 SHALL always be 0.
REQ-007 SHALL set scoreboard[id_rd_i] on accept when id_rd_we_i=1 and id_rd_i!=0.
REQ-008 SHALL clear scoreboard[wb_addr_i] when wb_valid_i=1.
REQ-009 SHALL give set priority over clear when both target the same bit in the same cycle.
REQ-010 SHALL define hazard=1 when id_valid_i=1 and any of the following holds:
- nonzero rs1 or rs2 has its scoreboard bit set and is not matched by the current writeback (RAW);
- id_rd_we_i=1, id_rd_i!=0, and scoreboard[id_rd_i] is set and not being cleared this cycle (WAW).
REQ-011 SHALL drive id_ready_o = !hazard && !flush_i && (!ex_valid_o || ex_ready_i).
REQ-012 SHALL accept when id_valid_i && id_ready_o; on accept, it SHALL register the resolved operands, id_rd_i and id_rd_we_i, and set ex_valid_o=1 on the next edge (latency 1 cycle).
REQ-013 SHALL clear ex_valid_o on the next edge when ex_valid_o && ex_ready_i and there is no accept.
REQ-014 SHALL hold all ex_* outputs stable while ex_valid_o=1 and ex_ready_i=0.
REQ-015 SHALL, on flush_i=1, clear ex_valid_o next edge; if ex_valid_o && ex_rd_we_o, it SHALL also clear scoreboard[ex_rd_o] unless it is simultaneously being set.
REQ-016 SHALL increment stall_cnt_o each cycle id_valid_i && hazard, saturating at 0xFFFF.
REQ-017 SHALL allow back-to-back accepts every cycle when hazard=0 and ex_ready_i=1.

Reset
REQ-018 SHALL, while rst_n_i=0, force ex_valid_o=0, ex_rs1_data_o=0, ex_rs2_data_o=0, ex_rd_o=0, ex_rd_we_o=0, scoreboard=0 and stall_cnt_o=0, immediately and independent of clk_i.
REQ-019 SHALL, after reset with ex_valid_o=0 and scoreboard=0, drive id_ready_o=1 unless flush_i=1.
REQ-020 SHALL discard any instruction presented during reset; an assert mid-handshake SHALL leave no residual scoreboard bits.

Verification
REQ-021 Bypass: rf_rdata1_i=0x11111111, wb_valid_i=1, wb_addr_i=5, wb_data_i=0xDEADBEEF, issue rs1=5 -> ex_rs1_data_o=0xDEADBEEF next cycle.
REQ-022 x0: rs1=0, rs2=0, rf_rdata=0xFFFFFFFF -> both operands 0; rd=0 with rd_we=1 leaves scoreboard unchanged.
REQ-023 RAW: accept rd=7 with rd_we=1, then issue rs2=7 -> id_ready_o=0 and stall_cnt_o increments each cycle; writeback of x7=0x42 -> same-cycle accept, ex_rs2_data_o=0x42.
REQ-024 Backpressure: ex_ready_i=0 for 3 cycles with ex_valid_o=1 -> ex_* stable and id_ready_o=0; ex_ready_i=1 -> next instruction accepted that cycle.
REQ-025 Flush: held rd=9 with rd_we=1, flush_i=1 -> ex_valid_o=0 next cycle, scoreboard[9]=0, and a later rs1=9 issues without stall.
REQ-026 Saturation: force a hazard for 70000 cycles -> stall_cnt_o=0xFFFF; async reset mid-stall -> all outputs 0 immediately.
